// File: rtl/cfu_job_master.sv
// Hardware job initiator for the matrix CFU: streams A/B words from a source
// memory, issues go, then drains C rows (four words each) into a destination memory.
module cfu_job_master #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] a_base,
    input  logic [ADDR_BITS-1:0] b_base,
    input  logic [ADDR_BITS-1:0] a_words,
    input  logic [ADDR_BITS-1:0] b_words,
    input  logic [ADDR_BITS-1:0] c_rows,
    input  logic [31:0]          kmn_word,
    input  logic [31:0]          input_offset,
    output logic                 busy,
    output logic                 done,
    output logic                 src_rd_en,
    output logic [ADDR_BITS-1:0] src_addr,
    input  logic [31:0]          src_data,
    output logic                 dst_wr_en,
    output logic [ADDR_BITS-1:0] dst_addr,
    output logic [31:0]          dst_data,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [9:0]           cmd_payload_function_id,
    output logic [31:0]          cmd_payload_inputs_0,
    output logic [31:0]          cmd_payload_inputs_1,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic [31:0]          rsp_payload_outputs_0
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, ISSUE, WAIT, NEXT, DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_A, PH_B, PH_GO, PH_C
    } phase_t;

    localparam logic [9:0] FN_WRITE_A = 10'h000;
    localparam logic [9:0] FN_WRITE_B = 10'h008;
    localparam logic [9:0] FN_READ_C  = 10'h010;
    localparam logic [9:0] FN_GO      = 10'h018;

    state_t state, state_n;
    phase_t phase, phase_n;

    logic [ADDR_BITS-1:0] i, i_n, r, r_n;
    logic [1:0]           o, o_n;
    logic [31:0]          in0, in0_n, in1, in1_n;
    logic [9:0]           fid, fid_n;

    logic [ADDR_BITS-1:0] a_base_q, b_base_q, a_words_q, b_words_q, c_rows_q;
    logic [31:0]          kmn_q, off_q;

    logic [ADDR_BITS-1:0] i_inc, r_inc;
    logic [1:0]           o_inc;
    logic                 rsp_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_A;
            i     <= '0;
            o     <= '0;
            r     <= '0;
            in0   <= '0;
            in1   <= '0;
            fid   <= '0;
        end else begin
            phase <= phase_n;
            i     <= i_n;
            o     <= o_n;
            r     <= r_n;
            in0   <= in0_n;
            in1   <= in1_n;
            fid   <= fid_n;
        end
    end

    // Job parameters are captured once so later changes on the ports are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_base_q  <= '0;
            b_base_q  <= '0;
            a_words_q <= '0;
            b_words_q <= '0;
            c_rows_q  <= '0;
            kmn_q     <= '0;
            off_q     <= '0;
        end else if (state == IDLE && start) begin
            a_base_q  <= a_base;
            b_base_q  <= b_base;
            a_words_q <= a_words;
            b_words_q <= b_words;
            c_rows_q  <= c_rows;
            kmn_q     <= kmn_word;
            off_q     <= input_offset;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        i_n     = i;
        o_n     = o;
        r_n     = r;
        in0_n   = in0;
        in1_n   = in1;
        fid_n   = fid;

        i_inc   = i + ADDR_BITS'(1);
        r_inc   = r + ADDR_BITS'(1);
        o_inc   = o + 2'd1;

        case (state)
            IDLE: begin
                if (start) begin
                    i_n = '0;
                    o_n = '0;
                    r_n = '0;
                    if (a_words != '0) begin
                        phase_n = PH_A;
                        state_n = FETCH;
                    end else if (b_words != '0) begin
                        phase_n = PH_B;
                        state_n = FETCH;
                    end else begin
                        phase_n = PH_GO;
                        state_n = ISSUE;
                        in0_n   = kmn_word;
                        in1_n   = input_offset;
                        fid_n   = FN_GO;
                    end
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                in0_n   = src_data;
                in1_n   = 32'(i);
                fid_n   = (phase == PH_B) ? FN_WRITE_B : FN_WRITE_A;
                state_n = ISSUE;
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_n = rsp_valid ? NEXT : WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                case (phase)
                    PH_A: begin
                        if (i_inc == a_words_q) begin
                            i_n = '0;
                            if (b_words_q != '0) begin
                                phase_n = PH_B;
                                state_n = FETCH;
                            end else begin
                                phase_n = PH_GO;
                                state_n = ISSUE;
                                in0_n   = kmn_q;
                                in1_n   = off_q;
                                fid_n   = FN_GO;
                            end
                        end else begin
                            i_n     = i_inc;
                            state_n = FETCH;
                        end
                    end
                    PH_B: begin
                        if (i_inc == b_words_q) begin
                            i_n     = '0;
                            phase_n = PH_GO;
                            state_n = ISSUE;
                            in0_n   = kmn_q;
                            in1_n   = off_q;
                            fid_n   = FN_GO;
                        end else begin
                            i_n     = i_inc;
                            state_n = FETCH;
                        end
                    end
                    PH_GO: begin
                        if (c_rows_q != '0) begin
                            phase_n = PH_C;
                            o_n     = '0;
                            r_n     = '0;
                            state_n = ISSUE;
                            in0_n   = '0;
                            in1_n   = '0;
                            fid_n   = FN_READ_C;
                        end else begin
                            state_n = DONE;
                        end
                    end
                    default: begin
                        // C words run o=0..3 within a row before stepping r.
                        if (o == 2'd3) begin
                            o_n = '0;
                            if (r_inc == c_rows_q) begin
                                state_n = DONE;
                            end else begin
                                r_n     = r_inc;
                                state_n = ISSUE;
                                in0_n   = '0;
                                in1_n   = 32'(r_inc);
                                fid_n   = FN_READ_C;
                            end
                        end else begin
                            o_n     = o_inc;
                            state_n = ISSUE;
                            in0_n   = 32'(o_inc);
                            in1_n   = 32'(r);
                            fid_n   = FN_READ_C;
                        end
                    end
                endcase
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rsp_take  = (state == ISSUE && cmd_ready && rsp_valid) || (state == WAIT && rsp_valid);

        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        src_rd_en = (state == FETCH);
        src_addr  = '0;
        if (state == FETCH) begin
            src_addr = ((phase == PH_B) ? b_base_q : a_base_q) + i;
        end

        cmd_valid               = (state == ISSUE);
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = in0;
        cmd_payload_inputs_1    = in1;
        rsp_ready               = (state == ISSUE) || (state == WAIT);

        dst_wr_en = rsp_take && (phase == PH_C);
        dst_addr  = '0;
        dst_data  = '0;
        if (dst_wr_en) begin
            dst_addr = (r << 2) + ADDR_BITS'(o);
            dst_data = rsp_payload_outputs_0;
        end
    end

endmodule

// File: tb/tb_cfu_job_master.sv
// Scoreboard bench for cfu_job_master with a small behavioural CFU and source memory.
module tb_cfu_job_master;

    localparam logic [31:0] KMN = 32'h0080_4408;
    localparam logic [31:0] OFF = 32'hFFFF_FF80;
    localparam logic [9:0]  FN_GO = 10'h018;
    localparam logic [9:0]  FN_RC = 10'h010;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] a_base, b_base, a_words, b_words, c_rows;
    logic [31:0] kmn_word, input_offset;
    logic        busy, done, src_rd_en, dst_wr_en, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [15:0] src_addr, dst_addr;
    logic [31:0] src_data = '0;
    logic [31:0] dst_data, cmd_in0, cmd_in1, rsp_data;
    logic [9:0]  cmd_fid;

    logic [31:0]  src_mem [0:65535];
    logic [127:0] c_mem [0:3];
    logic [127:0] c_shift;

    logic [15:0] src_q [$];
    logic [73:0] cmd_q [$];
    logic [47:0] dst_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    int   stall_idx = -1, stall_len = 0, go_dly = 0;
    int   cmd_cnt = 0, stall_ctr = 0, go_cnt = 0;
    logic go_pend = 1'b0;
    logic job_clr = 1'b0;

    cfu_job_master #(.ADDR_BITS(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_base(a_base), .b_base(b_base), .a_words(a_words), .b_words(b_words), .c_rows(c_rows),
        .kmn_word(kmn_word), .input_offset(input_offset),
        .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_fid),
        .cmd_payload_inputs_0(cmd_in0), .cmd_payload_inputs_1(cmd_in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CFU model: writes and reads answer in the handshake cycle, go optionally delayed.
    always_comb begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_cnt == stall_idx && stall_ctr < stall_len) cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        c_shift   = c_mem[cmd_in1[1:0]] >> (32 * (3 - int'(cmd_in0[1:0])));
        if (go_pend && go_cnt == go_dly) begin
            rsp_valid = 1'b1;
        end else if (cmd_valid && cmd_ready && !(cmd_fid == FN_GO && go_dly != 0)) begin
            rsp_valid = 1'b1;
            if (cmd_fid == FN_RC) rsp_data = c_shift[31:0];
        end
    end

    always @(posedge clk) begin
        if (reset || job_clr) begin
            cmd_cnt   <= 0;
            stall_ctr <= 0;
            go_pend   <= 1'b0;
            go_cnt    <= 0;
        end else begin
            if (cmd_valid && !cmd_ready) stall_ctr <= stall_ctr + 1;
            if (cmd_valid && cmd_ready) cmd_cnt <= cmd_cnt + 1;
            if (cmd_valid && cmd_ready && cmd_fid == FN_GO && go_dly != 0) begin
                go_pend <= 1'b1;
                go_cnt  <= 1;
            end else if (go_pend) begin
                if (rsp_valid) go_pend <= 1'b0;
                else go_cnt <= go_cnt + 1;
            end
        end
        if (src_rd_en) src_data <= src_mem[src_addr];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (src_rd_en) begin
                if (src_q.size() == 0) check("src_extra", src_q.size(), 1);
                else check("src_addr", src_addr, src_q.pop_front());
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) check("cmd_extra", cmd_q.size(), 1);
                else check("cmd", {cmd_fid, cmd_in0, cmd_in1}, cmd_q.pop_front());
            end
            if (cmd_valid && !cmd_ready && cmd_q.size() > 0)
                check("cmd_hold", {cmd_fid, cmd_in0, cmd_in1}, cmd_q[0]);
            if (dst_wr_en) begin
                if (dst_q.size() == 0) check("dst_extra", dst_q.size(), 1);
                else check("dst", {dst_addr, dst_data}, dst_q.pop_front());
            end
            if (go_pend && !rsp_valid) check("go_wait", {busy, rsp_ready, cmd_valid}, 3'b110);
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 0);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, {busy, done, src_rd_en, dst_wr_en, cmd_valid, rsp_ready}, 0);
        check({tag, "_addr"}, {src_addr, dst_addr}, 0);
        check({tag, "_payload"}, {cmd_fid, cmd_in0, cmd_in1, dst_data}, 0);
    endtask

    task automatic launch_job(input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] aw,
                              input logic [15:0] bw, input logic [15:0] cr,
                              input int s_idx, input int s_len, input int g_dly);
        logic [15:0]  addr;
        logic [127:0] entry;
        @(negedge clk);
        stall_idx = s_idx;
        stall_len = s_len;
        go_dly    = g_dly;
        a_base = ab; b_base = bb; a_words = aw; b_words = bw; c_rows = cr;
        kmn_word = KMN; input_offset = OFF;
        for (int k = 0; k < int'(aw); k++) begin
            addr = ab + 16'(k);
            src_q.push_back(addr);
            cmd_q.push_back({10'h000, src_mem[addr], 32'(k)});
        end
        for (int k = 0; k < int'(bw); k++) begin
            addr = bb + 16'(k);
            src_q.push_back(addr);
            cmd_q.push_back({10'h008, src_mem[addr], 32'(k)});
        end
        cmd_q.push_back({FN_GO, KMN, OFF});
        for (int r = 0; r < int'(cr); r++) begin
            entry = c_mem[r];
            for (int o = 0; o < 4; o++) begin
                cmd_q.push_back({FN_RC, 32'(o), 32'(r)});
                dst_q.push_back({16'(4 * r + o), entry[127 - 32 * o -: 32]});
            end
        end
        done_cnt = 0;
        start    = 1'b1;
        job_clr  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        job_clr = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int exp_cyc, input int restart_at);
        int cyc = 1;
        int done_at = 0;
        while (done_at == 0 && cyc <= 600) begin
            if (done) begin
                done_at = cyc;
            end else begin
                if (cyc == restart_at) begin
                    start   = 1'b1;
                    a_base  = 16'h7777;
                    a_words = 16'd9;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_cycles"}, done_at, exp_cyc);
        repeat (4) @(negedge clk);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_cmd_left"}, cmd_q.size(), 0);
        check({tag, "_src_left"}, src_q.size(), 0);
        check({tag, "_dst_left"}, dst_q.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) src_mem[k] = 32'hC0DE_0000 | 32'(k);
        src_mem[16'h0100] = 32'd11; src_mem[16'h0101] = 32'd22; src_mem[16'h0102] = 32'd33;
        src_mem[16'h0200] = 32'd44; src_mem[16'h0201] = 32'd55;
        c_mem[0] = 128'h0A0B0C0D_01020304_11121314_21222324;
        c_mem[1] = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        c_mem[2] = 128'h0;
        c_mem[3] = 128'h0;

        reset = 1'b1; start = 1'b0;
        a_base = '0; b_base = '0; a_words = '0; b_words = '0; c_rows = '0;
        kmn_word = '0; input_offset = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        // Baseline job: 4 cycles per write word, 2 per C word.
        launch_job(16'h0100, 16'h0200, 16'd3, 16'd2, 16'd2, -1, 0, 0);
        finish_job("basic", 39, 0);

        launch_job(16'h0100, 16'h0200, 16'd3, 16'd2, 16'd2, 1, 5, 0);
        finish_job("stall", 44, 0);

        launch_job(16'h0100, 16'h0200, 16'd3, 16'd2, 16'd2, -1, 0, 20);
        finish_job("go_delay", 59, 0);

        launch_job(16'h0100, 16'h0200, 16'd0, 16'd0, 16'd1, -1, 0, 0);
        finish_job("c_only", 11, 0);

        launch_job(16'h0100, 16'h0200, 16'd3, 16'd2, 16'd2, -1, 0, 0);
        finish_job("restart", 39, 5);

        // Abort during B phase, then a clean job.
        launch_job(16'h0100, 16'h0200, 16'd3, 16'd2, 16'd2, -1, 0, 0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("abort");
        reset = 1'b0;
        src_q.delete();
        cmd_q.delete();
        dst_q.delete();
        repeat (5) @(negedge clk);
        check("abort_done_count", done_cnt, 0);
        launch_job(16'h0100, 16'h0200, 16'd3, 16'd2, 16'd2, -1, 0, 0);
        finish_job("after_abort", 39, 0);

        launch_job(16'hFFFE, 16'h0200, 16'd3, 16'd0, 16'd0, -1, 0, 0);
        finish_job("wrap", 15, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_job_master.md
Name: cfu_job_master

Overview:
- Command initiator for the matrix CFU port; it drives the CPU side of the cmd/rsp handshake in hardware.
- On start it runs one job in order:
  - streams A words, then B words, from a source word memory into the CFU buffers;
  - issues the go command and waits for completion;
  - reads back every C row as four 32-bit words into a destination memory.
- Used by the system-level bench and by the hardware offload path in place of the CPU custom-instruction sequence.

Parameters:
- ADDR_BITS, 16, width of source/destination addresses and of all word/row counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- a_base  in  ADDR_BITS  source address of A word 0
- b_base  in  ADDR_BITS  source address of B word 0
- a_words  in  ADDR_BITS  number of A words to write
- b_words  in  ADDR_BITS  number of B words to write
- c_rows  in  ADDR_BITS  number of 128-bit C entries to read
- kmn_word  in  32  packed K[31:21], M[20:9], N[8:0] for go
- input_offset  in  32  go operand 1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the job completes
- src_rd_en  out  1  source read strobe; data returns next cycle on src_data
- src_addr  out  ADDR_BITS  source read address
- src_data  in  32  source read data
- dst_wr_en  out  1  destination write strobe
- dst_addr  out  ADDR_BITS  destination write address
- dst_data  out  32  destination write data
- cmd_valid  out  1  command valid to CFU
- cmd_ready  in  1  CFU accepts command
- cmd_payload_function_id  out  10  bits[4:3] opcode; all other bits 0
- cmd_payload_inputs_0  out  32  operand 0
- cmd_payload_inputs_1  out  32  operand 1
- rsp_valid  in  1  CFU response valid
- rsp_ready  out  1  master accepts response
- rsp_payload_outputs_0  in  32  response data

Behaviour:
- Reset:
  - all outputs 0; state IDLE; counters cleared.
  - Reset mid-job abandons the job with no done pulse; the CFU is reset in the same cycle.
- Opcodes on function_id[4:3]: 0 write_A, 1 write_B, 2 read_C, 3 go; function_id values are 0x000, 0x008, 0x010, 0x018.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - start=1 latches all job inputs, clears counters i and o, selects phase A.
  - Any phase with a zero count is skipped: A, then B, then GO (never skipped), then C.
  - start while busy is ignored.
- Write phases (A, B):
  - FETCH: src_rd_en=1, src_addr=base+i (mod 2^ADDR_BITS).
  - LATCH: src_data captured into the inputs_0 register.
  - ISSUE: cmd_valid=1, inputs_1 = i zero-extended.
- GO phase: skips FETCH/LATCH and enters ISSUE with inputs_0=kmn_word, inputs_1=input_offset.
- C phase:
  - Skips FETCH/LATCH and enters ISSUE with inputs_0=o (0..3) and inputs_1=r (row) zero-extended.
  - o=0 returns entry bits[127:96]; o=3 returns bits[31:0].
- ISSUE:
  - cmd_valid, function_id and payload are held stable until cmd_ready=1.
  - rsp_ready=1 in ISSUE and WAIT only.
  - A response in the same cycle as the command handshake completes the command; go NEXT. The CFU answers writes combinationally.
  - Otherwise go WAIT.
- WAIT: hold until rsp_valid=1, then go NEXT. rsp_valid outside ISSUE/WAIT is ignored (rsp_ready=0).
- Response capture (C phase):
  - On the accepted response cycle: dst_wr_en=1, dst_addr=4*r+o, dst_data=rsp_payload_outputs_0.
  - No dst write in any other phase.
- NEXT:
  - Write phases: i increments; when i reaches count, i clears and the next phase is selected.
  - C phase: o increments and wraps 3→0 with r+1; phase ends when r reaches c_rows.
  - Branches to FETCH for a write phase, ISSUE otherwise, DONE after C.
- DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE.
- Throughput with an always-ready CFU is 4 cycles per write word (FETCH, LATCH, ISSUE, NEXT) and 2 cycles per C word.
- Exactly one command is outstanding at any time.

Test Plan:
- a_words=3, b_words=2, c_rows=2, src[a_base..]=11,22,33, src[b_base..]=44,55, model CFU echoes:
  - cmds in order 0x000(11,0), (22,1), (33,2), 0x008(44,0), (55,1), 0x018(kmn,off);
  - then 0x010 with (o,r) = (0,0)..(3,0),(0,1)..(3,1);
  - 8 dst writes at addr 0..7, then a single done pulse.
- cmd_ready held low 5 cycles on the 2nd A command -> cmd_valid and payload (22,1) stable all 5 cycles; no extra src reads; sequence otherwise unchanged.
- CFU asserts go response 20 cycles after accept -> master stays in WAIT with busy=1 and rsp_ready=1; first read_C issued the cycle after NEXT.
- a_words=0, b_words=0, c_rows=1 -> no src_rd_en; only go then 4 read_C; C entry 0x0A0B0C0D_01020304_11121314_21222324 yields dst[0..3]=0A0B0C0D, 01020304, 11121314, 21222324.
- start pulsed again mid-job -> ignored, single done. Reset asserted during B phase -> all outputs 0 the next cycle, no done; a new start runs a full job correctly.
- a_base=0xFFFE, a_words=3 -> src_addr 0xFFFE, 0xFFFF, 0x0000 (wrap); inputs_1 = 0, 1, 2.
